// File: rtl/online_fuzzification_scheduler_if.sv
// Handshake bundle between the frame producer, the scheduler, the digit-serial
// fuzzifier and the result consumer.
interface online_fuzzification_scheduler_if #(
  parameter int DIGITS = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [5*DIGITS-1:0]   in_mu;
  logic                  fz_start;
  logic [4:0]            fz_inputs;
  logic                  fz_result_valid;
  logic [2:0]            fz_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_index;
  logic                  out_early;
  logic                  out_timeout;
  logic [4:0]            out_digits;

  // Scheduler side
  modport slave (
    input  in_valid, in_mu, fz_result_valid, fz_result, out_ready,
    output in_ready, fz_start, fz_inputs, out_valid, out_index, out_early,
           out_timeout, out_digits
  );

  // Environment side (producer, fuzzifier, consumer)
  modport master (
    output in_valid, in_mu, fz_result_valid, fz_result, out_ready,
    input  in_ready, fz_start, fz_inputs, out_valid, out_index, out_early,
           out_timeout, out_digits
  );
endinterface

// File: rtl/online_fuzzification_scheduler.sv
// Serialises five membership degrees MSB-first into an online fuzzifier and
// captures the winning lane index, with a bounded drain window and timeout.
module online_fuzzification_scheduler #(
  parameter int DIGITS    = 8,
  parameter int DRAIN_MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  online_fuzzification_scheduler_if.slave bus
);
  localparam int         LANES      = 5;
  localparam logic [4:0] LAST_DIGIT = 5'(DIGITS - 1);
  localparam logic [4:0] LAST_DRAIN = 5'(DIGITS + DRAIN_MAX - 1);
  localparam logic [4:0] TOTAL_CNT  = 5'(DIGITS + DRAIN_MAX);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [4:0]          cnt_reg, cnt_next;
  logic [DIGITS-1:0]   lane_reg  [LANES];
  logic [DIGITS-1:0]   lane_next [LANES];
  logic [DIGITS-1:0]   load_val  [LANES];
  logic [DIGITS-1:0]   shift_val [LANES];
  logic [2:0]          index_reg, index_next;
  logic                early_reg, early_next;
  logic                timeout_reg, timeout_next;
  logic [4:0]          digits_reg, digits_next;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign load_val[gi]      = bus.in_mu[gi*DIGITS +: DIGITS];
    assign shift_val[gi]     = lane_reg[gi] << 1;
    assign bus.fz_inputs[gi] = (state_reg == STREAM) & lane_reg[gi][DIGITS-1];
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.fz_start    = (state_reg == STREAM) || (state_reg == DRAIN);
  assign bus.out_valid   = (state_reg == HOLD);
  assign bus.out_index   = index_reg;
  assign bus.out_early   = early_reg;
  assign bus.out_timeout = timeout_reg;
  assign bus.out_digits  = digits_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    index_next   = index_reg;
    early_next   = early_reg;
    timeout_next = timeout_reg;
    digits_next  = digits_reg;
    for (int i = 0; i < LANES; i++) lane_next[i] = lane_reg[i];

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = STREAM;
          cnt_next   = '0;
          for (int i = 0; i < LANES; i++) lane_next[i] = load_val[i];
        end
      end
      STREAM: begin
        if (bus.fz_result_valid) begin
          state_next   = HOLD;
          index_next   = bus.fz_result;
          early_next   = (cnt_reg < LAST_DIGIT);
          timeout_next = 1'b0;
          digits_next  = cnt_reg + 5'd1;
        end else begin
          cnt_next = cnt_reg + 5'd1;
          for (int i = 0; i < LANES; i++) lane_next[i] = shift_val[i];
          if (cnt_reg == LAST_DIGIT) begin
            // With no drain window the last digit is also the deadline
            if (DRAIN_MAX == 0) begin
              state_next   = HOLD;
              index_next   = '0;
              early_next   = 1'b0;
              timeout_next = 1'b1;
              digits_next  = TOTAL_CNT;
            end else begin
              state_next = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // A result on the final drain cycle takes priority over the timeout
        if (bus.fz_result_valid) begin
          state_next   = HOLD;
          index_next   = bus.fz_result;
          early_next   = 1'b0;
          timeout_next = 1'b0;
          digits_next  = cnt_reg + 5'd1;
        end else if (cnt_reg == LAST_DRAIN) begin
          state_next   = HOLD;
          index_next   = '0;
          early_next   = 1'b0;
          timeout_next = 1'b1;
          digits_next  = TOTAL_CNT;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      index_reg   <= '0;
      early_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      digits_reg  <= '0;
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      index_reg   <= index_next;
      early_reg   <= early_next;
      timeout_reg <= timeout_next;
      digits_reg  <= digits_next;
      for (int i = 0; i < LANES; i++) lane_reg[i] <= lane_next[i];
    end
  end
endmodule

// File: tb/tb_online_fuzzification_scheduler.sv
// Bench for the fuzzification scheduler: directed vector table, mid-frame reset
// and randomized frames against a digit-level reference model.
module tb_online_fuzzification_scheduler;
  localparam int DIGITS    = 8;
  localparam int DRAIN_MAX = 2;
  localparam int TOTAL     = DIGITS + DRAIN_MAX;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  online_fuzzification_scheduler_if #(.DIGITS(DIGITS)) bus ();

  online_fuzzification_scheduler #(.DIGITS(DIGITS), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // k = 1-based fz_start cycle in which the stub reports a result (0 or >TOTAL: never)
  typedef struct {
    logic [39:0] mu;
    int          k;
    logic [2:0]  res;
    int          hold;
    logic [2:0]  e_index;
    logic        e_early;
    logic        e_timeout;
    logic [4:0]  e_digits;
  } vec_t;

  vec_t tbl [7];
  vec_t v;
  logic [39:0] mu_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome of a frame from the stub's response time alone
  function automatic vec_t model(input logic [39:0] mu, input int k, input logic [2:0] res,
                                 input int hold);
    vec_t r;
    r.mu = mu; r.k = k; r.res = res; r.hold = hold;
    if (k >= 1 && k <= TOTAL) begin
      r.e_index = res; r.e_early = (k < DIGITS); r.e_timeout = 1'b0; r.e_digits = 5'(k);
    end else begin
      r.e_index = 3'd0; r.e_early = 1'b0; r.e_timeout = 1'b1; r.e_digits = 5'(TOTAL);
    end
    return r;
  endfunction

  // Digit vector expected on fz_inputs in the j-th (1-based) fz_start cycle
  function automatic logic [4:0] digit_of(input logic [39:0] mu, input int j);
    logic [4:0] d;
    logic [7:0] lane;
    d = '0;
    for (int i = 0; i < 5; i++) begin
      lane = mu[i*DIGITS +: DIGITS];
      if (j <= DIGITS) d[i] = lane[DIGITS-j];
    end
    return d;
  endfunction

  task automatic check_result(input vec_t x, input string tag);
    check({tag, "_out_valid"},   bus.out_valid,   1);
    check({tag, "_out_index"},   bus.out_index,   x.e_index);
    check({tag, "_out_early"},   bus.out_early,   x.e_early);
    check({tag, "_out_timeout"}, bus.out_timeout, x.e_timeout);
    check({tag, "_out_digits"},  bus.out_digits,  x.e_digits);
    check({tag, "_hold_fz_start"}, bus.fz_start,  0);
    check({tag, "_hold_in_ready"}, bus.in_ready,  0);
  endtask

  task automatic run_frame(input vec_t x, input string tag);
    int waited;
    int n;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_idle_in_ready"}, bus.in_ready, 1);
    check({tag, "_idle_fz_start"}, bus.fz_start, 0);
    check({tag, "_idle_fz_inputs"}, bus.fz_inputs, 0);
    bus.in_mu    = x.mu;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mu    = '0;
    n = (x.k >= 1 && x.k <= TOTAL) ? x.k : TOTAL;
    for (int j = 1; j <= n; j++) begin
      check($sformatf("%s_c%0d_fz_start", tag, j), bus.fz_start, 1);
      check($sformatf("%s_c%0d_in_ready", tag, j), bus.in_ready, 0);
      check($sformatf("%s_c%0d_out_valid", tag, j), bus.out_valid, 0);
      check($sformatf("%s_c%0d_fz_inputs", tag, j), bus.fz_inputs, digit_of(x.mu, j));
      bus.fz_result_valid = (j == x.k);
      bus.fz_result       = x.res;
      @(negedge clk);
    end
    bus.fz_result_valid = 1'b0;
    check_result(x, tag);
    // Stray stub pulses while holding must not disturb the result
    for (int h = 0; h < x.hold; h++) begin
      bus.fz_result_valid = 1'($urandom_range(0, 1));
      bus.fz_result       = 3'($urandom_range(0, 7));
      @(negedge clk);
      check_result(x, $sformatf("%s_h%0d", tag, h));
    end
    bus.fz_result_valid = 1'b0;
    bus.out_ready       = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ret_out_valid"}, bus.out_valid, 0);
    check({tag, "_ret_in_ready"},  bus.in_ready,  1);
    check({tag, "_ret_fz_start"},  bus.fz_start,  0);
    $display("frame %s: mu=%h k=%0d res=%0d -> index=%0d early=%0b timeout=%0b digits=%0d",
             tag, x.mu, x.k, x.res, x.e_index, x.e_early, x.e_timeout, x.e_digits);
  endtask

  task automatic reset_mid_stream();
    logic [39:0] mu;
    mu = 40'hC35AF00F81;
    bus.in_mu    = mu;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int j = 1; j < 4; j++) @(negedge clk);
    check("rst_c4_fz_inputs", bus.fz_inputs, digit_of(mu, 4));
    bus.fz_result_valid = 1'b1;
    bus.fz_result       = 3'd2;
    rst_n = 1'b0;
    #1;
    check("rst_fz_start",    bus.fz_start,    0);
    check("rst_fz_inputs",   bus.fz_inputs,   0);
    check("rst_out_valid",   bus.out_valid,   0);
    check("rst_out_index",   bus.out_index,   0);
    check("rst_out_early",   bus.out_early,   0);
    check("rst_out_timeout", bus.out_timeout, 0);
    check("rst_out_digits",  bus.out_digits,  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.fz_result_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("rst_after%0d_out_valid", c), bus.out_valid, 0);
      check($sformatf("rst_after%0d_fz_start", c),  bus.fz_start,  0);
      check($sformatf("rst_after%0d_in_ready", c),  bus.in_ready,  1);
    end
    bus.fz_result_valid = 1'b0;
    $display("frame reset_mid_stream: aborted in cycle 4, no result emitted");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid        = 1'b0;
    bus.in_mu           = '0;
    bus.fz_result_valid = 1'b0;
    bus.fz_result       = '0;
    bus.out_ready       = 1'b0;

    tbl[0] = '{40'h0000A50000, 0,  3'd0, 0, 3'd0, 1'b0, 1'b1, 5'd10};
    tbl[1] = '{40'h123456789A, 3,  3'd3, 1, 3'd3, 1'b1, 1'b0, 5'd3};
    tbl[2] = '{40'hFF00FF00FF, 9,  3'd4, 0, 3'd4, 1'b0, 1'b0, 5'd9};
    tbl[3] = '{40'h0F0F0F0F0F, 10, 3'd6, 0, 3'd6, 1'b0, 1'b0, 5'd10};
    tbl[4] = '{40'h8040201008, 8,  3'd1, 2, 3'd1, 1'b0, 1'b0, 5'd8};
    tbl[5] = '{40'hFFFFFFFFFF, 1,  3'd7, 0, 3'd7, 1'b1, 1'b0, 5'd1};
    tbl[6] = '{40'h5A3CC3A55A, 0,  3'd5, 5, 3'd0, 1'b0, 1'b1, 5'd10};

    #12;
    check("reset_fz_start",    bus.fz_start,    0);
    check("reset_fz_inputs",   bus.fz_inputs,   0);
    check("reset_out_valid",   bus.out_valid,   0);
    check("reset_out_index",   bus.out_index,   0);
    check("reset_out_early",   bus.out_early,   0);
    check("reset_out_timeout", bus.out_timeout, 0);
    check("reset_out_digits",  bus.out_digits,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);

    for (int t = 0; t < 7; t++) run_frame(tbl[t], $sformatf("vec%0d", t));
    run_frame(tbl[1], "second_after_hold");

    reset_mid_stream();
    run_frame(tbl[2], "post_reset");

    for (int r = 0; r < 16; r++) begin
      mu_r = {8'($urandom), 32'($urandom)};
      v = model(mu_r, int'($urandom_range(0, TOTAL + 1)), 3'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)));
      run_frame(v, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
